// File: rtl/fifo_write_arbiter_if.sv
// Requester-side and FIFO-side signals of the FIFO write arbiter.
// The master drives requests and pops; the slave (the arbiter) drives ready, write data and status.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 128
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]       IN_reqValid;
  logic [NUM_REQ*WIDTH-1:0] IN_reqData;
  logic [NUM_REQ-1:0]       IN_reqLast;
  logic [NUM_REQ-1:0]       OUT_reqReady;
  logic [WIDTH-1:0]         OUT_fifoData;
  logic                     OUT_fifoValid;
  logic                     IN_fifoPop;
  logic [CW-1:0]            OUT_count;
  logic                     OUT_full;
  logic [GW-1:0]            OUT_grantIdx;
  logic                     OUT_locked;

  modport master (
    output IN_reqValid, IN_reqData, IN_reqLast, IN_fifoPop,
    input  OUT_reqReady, OUT_fifoData, OUT_fifoValid, OUT_count,
           OUT_full, OUT_grantIdx, OUT_locked
  );

  modport slave (
    input  IN_reqValid, IN_reqData, IN_reqLast, IN_fifoPop,
    output OUT_reqReady, OUT_fifoData, OUT_fifoValid, OUT_count,
           OUT_full, OUT_grantIdx, OUT_locked
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Burst-locked round-robin arbiter for a FIFO write port; accepted beat appears on OUT_fifo* one cycle later.
// Backpressure: ready only for the locked requester while the tracked occupancy is below DEPTH; one idle cycle per grant.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 128,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_write_arbiter_if.slave  bus
);
  localparam int GW  = $clog2(NUM_REQ);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             r_state;
  logic [GW-1:0]      r_rr_ptr;
  logic [GW-1:0]      r_grant_idx;
  logic [BCW-1:0]     r_beat_cnt;
  logic [CW-1:0]      r_count;
  logic               r_fifo_vld;
  logic [WIDTH-1:0]   r_fifo_dat;

  logic               w_full;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_accept;
  logic               w_burst_end;
  logic [WIDTH-1:0]   w_acc_dat;
  logic               w_any;
  logic               w_found;
  logic [GW-1:0]      w_scan;
  logic [GW-1:0]      w_pick;

  assign w_full = (r_count == CW'(DEPTH));

  // Ready depends only on registered state so requesters never see a valid->ready loop.
  always_comb begin
    w_ready = '0;
    if (r_state == S_BURST && !w_full) begin
      w_ready[r_grant_idx] = 1'b1;
    end
  end

  assign w_accept = |(bus.IN_reqValid & w_ready);

  always_comb begin
    w_acc_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == r_grant_idx) begin
        w_acc_dat = bus.IN_reqData[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_burst_end = w_accept &&
                       (bus.IN_reqLast[r_grant_idx] || (r_beat_cnt == BCW'(MAX_BURST - 1)));

  // First valid requester at or after the round-robin pointer, wrapping (NUM_REQ is a power of two).
  always_comb begin
    w_any   = |bus.IN_reqValid;
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_scan = r_rr_ptr + GW'(off);
      if (!w_found && bus.IN_reqValid[w_scan]) begin
        w_pick  = w_scan;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_beat_cnt  <= '0;
      r_count     <= '0;
      r_fifo_vld  <= 1'b0;
      r_fifo_dat  <= '0;
    end else begin
      r_fifo_vld <= w_accept;
      if (w_accept) begin
        r_fifo_dat <= w_acc_dat;
      end

      // A pop at zero occupancy is a protocol error upstream; hold at zero rather than wrap.
      case ({w_accept, bus.IN_fifoPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   if (r_count != '0) r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_idx <= w_pick;
            r_beat_cnt  <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_burst_end) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= r_grant_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.OUT_reqReady  = w_ready;
  assign bus.OUT_fifoData  = r_fifo_dat;
  assign bus.OUT_fifoValid = r_fifo_vld;
  assign bus.OUT_count     = r_count;
  assign bus.OUT_full      = w_full;
  assign bus.OUT_grantIdx  = r_grant_idx;
  assign bus.OUT_locked    = (r_state == S_BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a 4-entry FIFO, 4 requesters and 4-beat burst cap.
module tb_fifo_write_arbiter;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(D)) bus ();

  fifo_write_arbiter #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] d, input logic l);
    bus.IN_reqValid[i]       = v;
    bus.IN_reqData[i*W +: W] = d;
    bus.IN_reqLast[i]        = l;
  endtask

  task automatic clear_inputs();
    bus.IN_reqValid = '0;
    bus.IN_reqData  = '0;
    bus.IN_reqLast  = '0;
    bus.IN_fifoPop  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    clear_inputs();
    step();
    step();
    chk("rst_ready",  32'(bus.OUT_reqReady), 32'h0);
    chk("rst_fvld",   32'(bus.OUT_fifoValid), 32'h0);
    chk("rst_fdat",   bus.OUT_fifoData, 32'h0);
    chk("rst_count",  32'(bus.OUT_count), 32'h0);
    chk("rst_locked", 32'(bus.OUT_locked), 32'h0);
    chk("rst_grant",  32'(bus.OUT_grantIdx), 32'h0);
    chk("rst_rrptr",  32'(dut.r_rr_ptr), 32'h0);
    rst = 1'b1;

    // Single requester, three-beat burst
    set_req(0, 1'b1, 32'hA1, 1'b0);
    chk("t1_ready_before", 32'(bus.OUT_reqReady), 32'h0);
    step();
    chk("t1_ready0", 32'(bus.OUT_reqReady), 32'h1);
    chk("t1_locked", 32'(bus.OUT_locked), 32'h1);
    step();
    chk("t1_fvld1", 32'(bus.OUT_fifoValid), 32'h1);
    chk("t1_fdat1", bus.OUT_fifoData, 32'hA1);
    chk("t1_cnt1",  32'(bus.OUT_count), 32'h1);
    set_req(0, 1'b1, 32'hA2, 1'b0);
    step();
    chk("t1_fdat2", bus.OUT_fifoData, 32'hA2);
    chk("t1_cnt2",  32'(bus.OUT_count), 32'h2);
    set_req(0, 1'b1, 32'hA3, 1'b1);
    step();
    chk("t1_fvld3",   32'(bus.OUT_fifoValid), 32'h1);
    chk("t1_fdat3",   bus.OUT_fifoData, 32'hA3);
    chk("t1_cnt3",    32'(bus.OUT_count), 32'h3);
    chk("t1_unlock",  32'(bus.OUT_locked), 32'h0);
    chk("t1_rrptr",   32'(dut.r_rr_ptr), 32'h1);
    chk("t1_ready_off", 32'(bus.OUT_reqReady), 32'h0);
    set_req(0, 1'b0, 32'hA3, 1'b0);
    step();
    chk("t1_fvld_idle", 32'(bus.OUT_fifoValid), 32'h0);
    chk("t1_fdat_hold", bus.OUT_fifoData, 32'hA3);

    // Fairness: everyone valid with single-beat bursts; pops keep the count at zero
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 1'b1);
    bus.IN_fifoPop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_grant",  32'(bus.OUT_grantIdx), 32'(k % 4));
      chk("t2_ready",  32'(bus.OUT_reqReady), 32'(1 << (k % 4)));
      step();
      chk("t2_fvld",   32'(bus.OUT_fifoValid), 32'h1);
      chk("t2_fdat",   bus.OUT_fifoData, 32'h100 + 32'(k % 4));
      chk("t2_bubble", 32'(bus.OUT_reqReady), 32'h0);
    end
    chk("t2_cnt", 32'(bus.OUT_count), 32'h0);

    // Burst cap: req2 never sends last, req3 waits
    do_reset();
    bus.IN_fifoPop = 1'b1;
    set_req(3, 1'b1, 32'h333, 1'b1);
    set_req(2, 1'b1, 32'h200, 1'b0);
    step();
    chk("t3_grant2", 32'(bus.OUT_grantIdx), 32'h2);
    for (int b = 0; b < 4; b++) begin
      set_req(2, 1'b1, 32'h200 + 32'(b), 1'b0);
      step();
      chk("t3_fvld", 32'(bus.OUT_fifoValid), 32'h1);
      chk("t3_fdat", bus.OUT_fifoData, 32'h200 + 32'(b));
    end
    chk("t3_unlock", 32'(bus.OUT_locked), 32'h0);
    step();
    chk("t3_grant3", 32'(bus.OUT_grantIdx), 32'h3);
    chk("t3_ready3", 32'(bus.OUT_reqReady), 32'h8);

    // Full: no pops until the FIFO holds DEPTH entries
    do_reset();
    set_req(1, 1'b1, 32'h300, 1'b0);
    step();
    for (int n = 0; n < 4; n++) begin
      set_req(1, 1'b1, 32'h300 + 32'(n), 1'b0);
      step();
      chk("t4_fdat", bus.OUT_fifoData, 32'h300 + 32'(n));
    end
    chk("t4_cnt4", 32'(bus.OUT_count), 32'h4);
    chk("t4_full", 32'(bus.OUT_full), 32'h1);
    step();
    chk("t4_relock",     32'(bus.OUT_locked), 32'h1);
    chk("t4_ready_full", 32'(bus.OUT_reqReady), 32'h0);
    step();
    chk("t4_fvld_full",  32'(bus.OUT_fifoValid), 32'h0);
    chk("t4_cnt_hold",   32'(bus.OUT_count), 32'h4);
    bus.IN_fifoPop = 1'b1;
    set_req(1, 1'b1, 32'h304, 1'b0);
    step();
    chk("t4_no_bypass", 32'(bus.OUT_count), 32'h3);
    chk("t4_fvld_pop",  32'(bus.OUT_fifoValid), 32'h0);
    chk("t4_ready_back", 32'(bus.OUT_reqReady), 32'h2);
    bus.IN_fifoPop = 1'b0;
    step();
    chk("t4_fvld_last", 32'(bus.OUT_fifoValid), 32'h1);
    chk("t4_fdat_last", bus.OUT_fifoData, 32'h304);
    chk("t4_cnt_last",  32'(bus.OUT_count), 32'h4);

    // Accept and pop together, then a stray pop at empty
    do_reset();
    set_req(0, 1'b1, 32'h500, 1'b0);
    step();
    step();
    step();
    chk("t5_cnt2", 32'(bus.OUT_count), 32'h2);
    bus.IN_fifoPop = 1'b1;
    step();
    chk("t5_both_cnt",  32'(bus.OUT_count), 32'h2);
    chk("t5_both_fvld", 32'(bus.OUT_fifoValid), 32'h1);
    set_req(0, 1'b0, 32'h500, 1'b0);
    step();
    chk("t5_pop_cnt1", 32'(bus.OUT_count), 32'h1);
    step();
    chk("t5_pop_cnt0", 32'(bus.OUT_count), 32'h0);
    step();
    chk("t5_stray_pop", 32'(bus.OUT_count), 32'h0);
    bus.IN_fifoPop = 1'b0;

    // Reset in the middle of a burst with a non-zero round-robin pointer
    do_reset();
    set_req(2, 1'b1, 32'h600, 1'b1);
    step();
    step();
    chk("t6_rrptr3", 32'(dut.r_rr_ptr), 32'h3);
    set_req(2, 1'b1, 32'h601, 1'b0);
    step();
    chk("t6_grant2", 32'(bus.OUT_grantIdx), 32'h2);
    step();
    step();
    chk("t6_cnt3",   32'(bus.OUT_count), 32'h3);
    chk("t6_locked", 32'(bus.OUT_locked), 32'h1);
    rst = 1'b0;
    #1;
    chk("t6_rst_ready",  32'(bus.OUT_reqReady), 32'h0);
    chk("t6_rst_fvld",   32'(bus.OUT_fifoValid), 32'h0);
    chk("t6_rst_cnt",    32'(bus.OUT_count), 32'h0);
    chk("t6_rst_locked", 32'(bus.OUT_locked), 32'h0);
    chk("t6_rst_rrptr",  32'(dut.r_rr_ptr), 32'h0);
    chk("t6_rst_grant",  32'(bus.OUT_grantIdx), 32'h0);
    clear_inputs();
    set_req(0, 1'b1, 32'h700, 1'b1);
    set_req(3, 1'b1, 32'h703, 1'b1);
    #1;
    rst = 1'b1;
    step();
    chk("t6_restart_grant", 32'(bus.OUT_grantIdx), 32'h0);
    chk("t6_restart_ready", 32'(bus.OUT_reqReady), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
